// File: rtl/serial_subtractor8.sv
// serial_subtractor8: bit-serial subtractor with a start/busy/done handshake.
//
// The minuend and subtrahend are captured in parallel when a start is accepted.
// Both operands are then shifted LSB-first through a 1-bit full subtractor.
// The difference bits enter the result register from the top.
// After WIDTH shifts, done_o pulses for one cycle. d_o and bout_o then hold
// the result until the next start is accepted.
//
// Optional feature (macro SUB_OVF_EN): adds ovf_o, the signed-overflow flag.
// It is computed at the final shift from the operand MSBs latched at capture.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset
//   start_i  operation request, sampled only while idle
//   a_i      minuend, captured on accepted start
//   b_i      subtrahend, captured on accepted start
//   bin_i    borrow-in, captured on accepted start
//   busy_o   high while shifting
//   done_o   one-cycle pulse, result valid
//   d_o      difference a - b - bin (mod 2^WIDTH)
//   bout_o   borrow-out (unsigned a < b + bin)
//   ovf_o    signed overflow (SUB_OVF_EN only)
module serial_subtractor8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] d_o,
    output logic             bout_o
`ifdef SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    // Wide enough to hold WIDTH itself so the counter never wraps mid-operation.
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   count_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              br_q;
    logic [WIDTH-1:0]  d_q;
    logic              bout_q;
    logic              busy_q;
    logic              done_q;
`ifdef SUB_OVF_EN
    logic              a_msb_q;
    logic              b_msb_q;
    logic              ovf_q;
`endif

    logic              diff_bit;
    logic              br_d;
    logic              last_shift;

    // 1-bit full subtractor on the current operand LSBs.
    always_comb begin
        diff_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_d       = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
        last_shift = (count_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        br_q    <= bin_i;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
`ifdef SUB_OVF_EN
                        a_msb_q <= a_i[WIDTH-1];
                        b_msb_q <= b_i[WIDTH-1];
`endif
                    end
                end
                StShift: begin
                    d_q     <= {diff_bit, d_q[WIDTH-1:1]};
                    a_q     <= {1'b0, a_q[WIDTH-1:1]};
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    br_q    <= br_d;
                    count_q <= count_q + CntW'(1);
                    if (last_shift) begin
                        bout_q  <= br_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
`ifdef SUB_OVF_EN
                        // diff_bit is the result MSB on the final shift.
                        ovf_q   <= (a_msb_q ^ b_msb_q) & (diff_bit ^ a_msb_q);
`endif
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign d_o    = d_q;
    assign bout_o = bout_q;
`ifdef SUB_OVF_EN
    assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor8.sv
// Scoreboard bench for serial_subtractor8. Stimulus pushes the arithmetic
// expectation into a queue, and a negedge monitor pops it on every done pulse.
module tb_serial_subtractor8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    logic [9:0]   exp_q[$];   // {ovf, bout, D}
    logic [9:0]   mon_e;
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    int           cyc = 0;
    int           last_done_cyc = 0;
    bit           last_valid = 1'b0;
    int           busy_run = 0;
    int           n_ops = 0;
    int           saved;

    serial_subtractor8 #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .a_i    (a),
        .b_i    (b),
        .bin_i  (bin),
        .busy_o (busy),
        .done_o (done),
        .d_o    (d),
        .bout_o (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf_o  (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else if (done) begin
            done_cnt++;
            check("busy_len", busy_run, 8);
            check("busy_at_done", {31'b0, busy}, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty queue, expected none");
            end else begin
                mon_e = exp_q.pop_front();
                check("D", {24'b0, d}, {24'b0, mon_e[7:0]});
                check("bout", {31'b0, bout}, {31'b0, mon_e[8]});
`ifdef SUB_OVF_EN
                check("ovf", {31'b0, ovf}, {31'b0, mon_e[9]});
`endif
            end
            if (last_valid) check("done_spacing", cyc - last_done_cyc, W + 2);
            last_done_cyc = cyc;
            last_valid    = 1'b1;
            busy_run      = 0;
        end else if (busy) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    // One operation issued in the earliest back-to-back slot. Inputs are
    // scrambled after capture, and start is optionally re-pulsed while busy.
    task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic bni,
                         input bit repulse);
        logic [8:0] full;
        int         r;
        logic       ov;
        @(negedge clk);
        a     = ai;
        b     = bi;
        bin   = bni;
        start = 1'b1;
        full  = {1'b0, ai} - {1'b0, bi} - {8'b0, bni};
        r     = int'($signed(ai)) - int'($signed(bi)) - int'(bni);
        ov    = (r < -128) || (r > 127);
        exp_q.push_back({ov, full});
        n_ops++;
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        bin   = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = (repulse && i < W - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (repulse) a = 8'($urandom);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #2;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_D", {24'b0, d}, 0);
        check("rst_bout", {31'b0, bout}, 0);
`ifdef SUB_OVF_EN
        check("rst_ovf", {31'b0, ovf}, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a shift sequence; no expectation is queued.
        @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        bin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        saved = done_cnt;
        rst   = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_D", {24'b0, d}, 0);
        check("midrst_bout", {31'b0, bout}, 0);
        check("midrst_done", {31'b0, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("no_done_after_rst", done_cnt, saved);
        last_valid = 1'b0;

        // Directed cases and corners.
        issue(8'h5A, 8'h3C, 1'b0, 1'b0);
        issue(8'h00, 8'h01, 1'b0, 1'b0);
        issue(8'h80, 8'h01, 1'b0, 1'b0);
        issue(8'h10, 8'h0F, 1'b1, 1'b1);
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        issue(8'h00, 8'hFF, 1'b1, 1'b0);
        issue(8'h7F, 8'h80, 1'b0, 1'b0);
        issue(8'h80, 8'h7F, 1'b1, 1'b1);
        issue(8'hFF, 8'h00, 1'b0, 1'b0);

        // Randomised back-to-back traffic.
        for (int k = 0; k < 3000; k++) begin
            issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("done_total", done_cnt, saved + n_ops);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
